// File: rtl/conv_pe_quant_if.sv
// Beat/result bundle between the conv front-end, the PE and the
// output-channel writer.
interface conv_pe_quant_if #(
    parameter int CH    = 8,
    parameter int ACC_W = 32
);
    logic                    ce;
    logic                    valid_in;
    logic                    last_channel;
    logic                    kernel_1x1;
    logic [9*CH*8-1:0]       pixels;
    logic [9*CH*8-1:0]       weights;
    logic signed [31:0]      bias;
    logic [4:0]              shift;
    logic                    relu_en;
    logic signed [ACC_W-1:0] acc_out;
    logic signed [7:0]       q_out;
    logic                    q_clip;
    logic                    ovf;
    logic                    data_valid;

    modport master (
        output ce, valid_in, last_channel, kernel_1x1,
        output pixels, weights, bias, shift, relu_en,
        input  acc_out, q_out, q_clip, ovf, data_valid
    );

    modport slave (
        input  ce, valid_in, last_channel, kernel_1x1,
        input  pixels, weights, bias, shift, relu_en,
        output acc_out, q_out, q_clip, ovf, data_valid
    );
endinterface

// File: rtl/conv_pe_quant.sv
// 3x3 / 1x1 int8 convolution PE: multi-beat accumulate, then bias,
// leaky-ReLU, round-shift and int8 clamp. Six-register pipeline.
module conv_pe_quant #(
    parameter int CH    = 8,
    parameter int ACC_W = 32
) (
    input logic            clk,
    input logic            rst,
    conv_pe_quant_if.slave bus
);
    localparam int TW = 16 + $clog2(CH);
    localparam int BW = 16 + $clog2(9 * CH);
    localparam int XW = 34;
    localparam logic signed [XW-1:0] AMAX = (XW'(1) <<< (ACC_W - 1)) - XW'(1);
    localparam logic signed [XW-1:0] AMIN = ~AMAX;
    localparam logic signed [XW-1:0] QMAX = XW'(127);
    localparam logic signed [XW-1:0] QMIN = -XW'(128);

    typedef struct packed {
        logic               valid;
        logic               last;
        logic               relu;
        logic [4:0]         shift;
        logic signed [31:0] bias;
    } ctl_t;

    function automatic logic signed [15:0] mul8(input logic [7:0] a,
                                                input logic [7:0] b);
        logic signed [15:0] ea;
        logic signed [15:0] eb;
        ea = 16'($signed(a));
        eb = 16'($signed(b));
        return ea * eb;
    endfunction

    function automatic logic signed [ACC_W-1:0] sat(
        input logic signed [XW-1:0] x);
        if (x > AMAX) return ACC_W'(AMAX);
        if (x < AMIN) return ACC_W'(AMIN);
        return ACC_W'(x);
    endfunction

    ctl_t c1, c2, c3, c4, c5;
    logic signed [15:0]      prod [9][CH];
    logic signed [TW-1:0]    tsum [9];
    logic signed [TW-1:0]    tsum_d [9];
    logic signed [BW-1:0]    bsum, bsum_d;
    logic signed [ACC_W-1:0] acc, tot, y_raw, y_act;
    logic signed [ACC_W-1:0] n4, n5, ya;
    logic signed [XW-1:0]    s4, s5, yx, rnd, rr;
    logic                    o4, o5, qc, ovf_r, dv_r;
    logic [7:0]              qv;

    // Products carry no reset so they can map onto DSP multipliers.
    always_ff @(posedge clk) begin
        if (bus.ce) begin
            for (int t = 0; t < 9; t++) begin
                for (int c = 0; c < CH; c++) begin
                    prod[t][c] <= (bus.kernel_1x1 && t != 4) ? '0 :
                        mul8(bus.pixels[(t*CH+c)*8 +: 8],
                             bus.weights[(t*CH+c)*8 +: 8]);
                end
            end
            tsum <= tsum_d;
            bsum <= bsum_d;
        end
    end

    always_comb begin
        for (int t = 0; t < 9; t++) begin
            tsum_d[t] = '0;
            for (int c = 0; c < CH; c++) tsum_d[t] += TW'(prod[t][c]);
        end
        bsum_d = '0;
        for (int t = 0; t < 9; t++) bsum_d += BW'(tsum[t]);
    end

    always_comb begin
        s4  = XW'(acc) + XW'(bsum);
        o4  = (s4 > AMAX) || (s4 < AMIN);
        n4  = sat(s4);
        s5  = XW'(tot) + XW'(c4.bias);
        o5  = (s5 > AMAX) || (s5 < AMIN);
        n5  = sat(s5);
        ya  = (c4.relu && n5[ACC_W-1]) ? (n5 >>> 3) : n5;
        yx  = XW'(y_act);
        rnd = (c5.shift == 5'd0) ? '0 : (XW'(1) <<< (c5.shift - 5'd1));
        rr  = (yx + rnd) >>> c5.shift;
        qc  = (rr > QMAX) || (rr < QMIN);
        qv  = (rr > QMAX) ? 8'h7f : (rr < QMIN) ? 8'h80 : rr[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            c1          <= '0;
            c2          <= '0;
            c3          <= '0;
            c4          <= '0;
            c5          <= '0;
            acc         <= '0;
            ovf_r       <= 1'b0;
            dv_r        <= 1'b0;
            bus.acc_out <= '0;
            bus.q_out   <= '0;
            bus.q_clip  <= 1'b0;
        end else if (bus.ce) begin
            c1.valid <= bus.valid_in;
            c1.last  <= bus.valid_in & bus.last_channel;
            c1.relu  <= bus.relu_en;
            c1.shift <= bus.shift;
            c1.bias  <= bus.bias;
            c2       <= c1;
            c3       <= c2;
            // From here on valid marks a finished pixel, not a beat.
            c4       <= c3;
            c4.valid <= c3.last;
            c5       <= c4;
            if (c3.valid) acc <= c3.last ? '0 : n4;
            if (c3.last) tot <= n4;
            y_raw <= n5;
            y_act <= ya;
            ovf_r <= ovf_r | (c3.valid & o4) | (c4.valid & o5);
            dv_r  <= c5.valid;
            if (c5.valid) begin
                bus.acc_out <= y_raw;
                bus.q_out   <= qv;
                bus.q_clip  <= qc;
            end
        end
    end

    assign bus.ovf        = ovf_r;
    assign bus.data_valid = dv_r & bus.ce;
endmodule
